// File: rtl/alu_mdu_pkg.sv
// Shared constants for the EX-stage ALU/MDU: funct codes and FSM state encoding.
package alu_mdu_pkg;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    typedef enum logic [1:0] {IDLE = ST_IDLE, MUL = ST_MUL, DIV = ST_DIV} state_e;
endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the issue logic (master) and the ALU/MDU (slave).
interface alu_mdu_if #(parameter int WIDTH = 32);
    localparam int SHW = $clog2(WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       funct;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic [WIDTH-1:0] data_out;
    logic             ovf;
    logic             illegal;

    modport master (output in_valid, funct, data_a, data_b, shamt,
                    input  in_ready, out_valid, data_out, ovf, illegal);
    modport slave  (input  in_valid, funct, data_a, data_b, shamt,
                    output in_ready, out_valid, data_out, ovf, illegal);
endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative shift-add multiplier / restoring divider, one step per cycle for WIDTH cycles.
// The divide datapath only exists when ALU_MDU_DIVU_EN is defined.
module alu_mdu_iter #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opb;
    logic [WIDTH:0]   sum;
`ifdef ALU_MDU_DIVU_EN
    logic             div_mode;
    logic [WIDTH:0]   shifted, diff;
`endif

    always_comb begin
        // multiply: acc_lo holds the remaining multiplier bits, product grows into acc_hi
        sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        hi  = sum[WIDTH:1];
        lo  = {sum[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_MDU_DIVU_EN
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, opb};
        if (div_mode) begin
            // diff[WIDTH] set means the trial subtract borrowed: restore
            if (!diff[WIDTH]) begin
                hi = diff[WIDTH-1:0];
                lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi = shifted[WIDTH-1:0];
                lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // hi/lo carry the post-step value, so the final step is captured on the done edge
    assign done = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb    <= '0;
`ifdef ALU_MDU_DIVU_EN
            div_mode <= 1'b0;
`endif
        end else if (start) begin
            cnt    <= CW'(WIDTH);
            acc_hi <= '0;
            acc_lo <= is_div ? op_a : op_b;
            opb    <= is_div ? op_b : op_a;
`ifdef ALU_MDU_DIVU_EN
            div_mode <= is_div;
`endif
        end else if (cnt != '0) begin
            cnt    <= cnt - CW'(1);
            acc_hi <= hi;
            acc_lo <= lo;
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with registered result plus iterative MULTU (and DIVU when
// ALU_MDU_DIVU_EN is defined) into HI/LO; in_ready drops while the MDU is busy.
module alu_mdu
    import alu_mdu_pkg::*;
#(parameter int WIDTH = 32) (
    input  logic      clk,
    input  logic      rst_n,
    alu_mdu_if.slave  bus
);
    state_e           state_q, state_d;
    logic             xfer, mdu_go, div_go, ill_c, ovf_c;
    logic [WIDTH-1:0] res, sum, dif, hi_q, lo_q, it_hi, it_lo, dout_q;
    logic             it_done, vld_q, ovf_q, ill_q;

    assign bus.in_ready  = (state_q == IDLE);
    assign xfer          = bus.in_valid && bus.in_ready;
    assign sum           = bus.data_a + bus.data_b;
    assign dif           = bus.data_a - bus.data_b;
    assign bus.out_valid = vld_q;
    assign bus.data_out  = dout_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = ill_q;

    always_comb begin
        res    = '0;
        ovf_c  = 1'b0;
        ill_c  = 1'b0;
        mdu_go = 1'b0;
        div_go = 1'b0;
        case (bus.funct)
            F_AND:  res = bus.data_a & bus.data_b;
            F_OR:   res = bus.data_a | bus.data_b;
            F_ADD: begin
                res   = sum;
                ovf_c = (bus.data_a[WIDTH-1] == bus.data_b[WIDTH-1]) &&
                        (sum[WIDTH-1] != bus.data_a[WIDTH-1]);
            end
            F_SUB: begin
                res   = dif;
                ovf_c = (bus.data_a[WIDTH-1] != bus.data_b[WIDTH-1]) &&
                        (dif[WIDTH-1] != bus.data_a[WIDTH-1]);
            end
            F_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(bus.data_a) < $signed(bus.data_b))};
            F_SLL:  res = bus.data_b << bus.shamt;
            F_SRL:  res = bus.data_b >> bus.shamt;
            F_SRA:  res = WIDTH'($signed(bus.data_b) >>> bus.shamt);
            F_MFHI: res = hi_q;
            F_MFLO: res = lo_q;
            F_MULTU: mdu_go = 1'b1;
`ifdef ALU_MDU_DIVU_EN
            F_DIVU: begin
                mdu_go = 1'b1;
                div_go = 1'b1;
            end
`endif
            default: ill_c = 1'b1;
        endcase
    end

    alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk(clk), .rst_n(rst_n),
        .start(xfer && mdu_go), .is_div(div_go),
        .op_a(bus.data_a), .op_b(bus.data_b),
        .done(it_done), .hi(it_hi), .lo(it_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (xfer && mdu_go) begin
`ifdef ALU_MDU_DIVU_EN
                state_d = div_go ? DIV : MUL;
`else
                state_d = MUL;
`endif
            end
            default: if (it_done) state_d = IDLE;
        endcase
    end

    // flags are forced low on every cycle without a result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            ill_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (it_done) begin
            vld_q  <= 1'b1;
            dout_q <= it_lo;
            ovf_q  <= 1'b0;
            ill_q  <= 1'b0;
            hi_q   <= it_hi;
            lo_q   <= it_lo;
        end else if (xfer && !mdu_go) begin
            vld_q  <= 1'b1;
            dout_q <= res;
            ovf_q  <= ovf_c;
            ill_q  <= ill_c;
        end else begin
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
            ill_q  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Randomised self-checking bench for alu_mdu (WIDTH=32) against an arithmetic reference model.
module tb_alu_mdu;
    import alu_mdu_pkg::*;
    localparam int W = 32;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(W)) bus();
    alu_mdu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0, n_fail = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [5:0]  ops [10] = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_SRL, F_SRA, F_MFHI, F_MFLO};

    // drive one op at a negedge; returns at the next negedge, when its single-cycle result is visible
    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        bus.in_valid = 1'b1; bus.funct = f; bus.data_a = a; bus.data_b = b; bus.shamt = sh;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    function automatic void ref_single(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] sh, output logic [31:0] r, output logic o, output logic il);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        longint maxs = 64'sd2147483647;
        longint mins = -64'sd2147483648;
        r = '0; o = 1'b0; il = 1'b0;
        case (f)
            F_AND:  r = a & b;
            F_OR:   r = a | b;
            F_ADD:  begin s = sa + sb; r = 32'(s); o = (s > maxs) || (s < mins); end
            F_SUB:  begin s = sa - sb; r = 32'(s); o = (s > maxs) || (s < mins); end
            F_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            F_SLL:  r = b << sh;
            F_SRL:  r = b >> sh;
            F_SRA:  begin s = sb >>> sh; r = 32'(s); end
            F_MFHI: r = m_hi;
            F_MFLO: r = m_lo;
            default: il = 1'b1;
        endcase
    endfunction

    task automatic test_reset();
        #12;
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.data_out !== 32'h0 ||
            bus.ovf !== 1'b0 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b dout=%h ovf=%b ill=%b, want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.data_out, bus.ovf, bus.illegal);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive(F_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.data_out !== 32'h8000_0000 || bus.ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL add_ovf: vld=%b dout=%h ovf=%b, want 1 80000000 1", bus.out_valid, bus.data_out, bus.ovf);
        end
        drive(F_SUB, 32'd5, 32'd7, 5'd0);
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.data_out !== 32'hFFFF_FFFE || bus.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_b2b: vld=%b dout=%h ovf=%b, want 1 fffffffe 0", bus.out_valid, bus.data_out, bus.ovf);
        end
        @(negedge clk);
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.ovf !== 1'b0 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_flags: vld=%b ovf=%b ill=%b, want 0 0 0", bus.out_valid, bus.ovf, bus.illegal);
        end
    endtask

    task automatic test_slt_shift();
        drive(F_SLT, 32'h8000_0000, 32'h1, 5'd0);
        n_chk++;
        if (bus.data_out !== 32'd1) begin
            n_fail++; $display("FAIL slt_neg: got %h want 00000001", bus.data_out);
        end
        drive(F_SLT, 32'h1, 32'h8000_0000, 5'd0);
        n_chk++;
        if (bus.data_out !== 32'd0) begin
            n_fail++; $display("FAIL slt_pos: got %h want 00000000", bus.data_out);
        end
        drive(F_SRA, 32'h0, 32'h8000_0000, 5'd4);
        n_chk++;
        if (bus.data_out !== 32'hF800_0000) begin
            n_fail++; $display("FAIL sra: got %h want f8000000", bus.data_out);
        end
    endtask

    task automatic test_random_single();
        logic [5:0] f; logic [31:0] a, b, r; logic [4:0] sh; logic o, il;
        for (int i = 0; i < 200; i++) begin
            f = ops[$urandom_range(0, 9)];
            a = rnd32(); b = rnd32(); sh = 5'($urandom);
            ref_single(f, a, b, sh, r, o, il);
            drive(f, a, b, sh);
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.data_out !== r || bus.ovf !== o || bus.illegal !== il) begin
                n_fail++;
                $display("FAIL rand_op f=%b a=%h b=%h sh=%0d: vld=%b dout=%h ovf=%b ill=%b, want 1 %h %b %b",
                         f, a, b, sh, bus.out_valid, bus.data_out, bus.ovf, bus.illegal, r, o, il);
            end
        end
    endtask

    task automatic test_multu();
        logic [31:0] a, b; logic [63:0] p; int lat, low;
        for (int i = 0; i < 5; i++) begin
            a = (i == 0) ? 32'hFFFF_FFFF : rnd32();
            b = (i == 0) ? 32'hFFFF_FFFF : $urandom;
            p = 64'(a) * 64'(b);
            drive(F_MULTU, a, b, 5'd0);
            lat = 1; low = (bus.in_ready == 1'b0) ? 1 : 0;
            while (!bus.out_valid && lat < 100) begin
                @(negedge clk); lat++;
                if (!bus.in_ready) low++;
            end
            m_hi = p[63:32]; m_lo = p[31:0];
            n_chk++;
            if (lat != 33 || low != 32 || bus.in_ready !== 1'b1) begin
                n_fail++; $display("FAIL mul_timing: lat=%0d low=%0d rdy=%b, want 33 32 1", lat, low, bus.in_ready);
            end
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.data_out !== m_lo || bus.ovf !== 1'b0 || bus.illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL mul_lo a=%h b=%h: vld=%b dout=%h ovf=%b ill=%b, want 1 %h 0 0",
                         a, b, bus.out_valid, bus.data_out, bus.ovf, bus.illegal, m_lo);
            end
            drive(F_MFHI, $urandom, $urandom, 5'd0);
            n_chk++;
            if (bus.data_out !== m_hi) begin
                n_fail++; $display("FAIL mul_hi a=%h b=%h: got %h want %h", a, b, bus.data_out, m_hi);
            end
        end
    endtask

    task automatic test_mflo_hold();
        logic [31:0] a, b; logic [63:0] p; int c, pulses, first, second; logic [31:0] got;
        a = $urandom; b = $urandom; p = 64'(a) * 64'(b);
        drive(F_MULTU, a, b, 5'd0);
        bus.in_valid = 1'b1; bus.funct = F_MFLO;
        c = 1; pulses = 0; first = 0; second = 0; got = '0;
        while (c < 100) begin
            if (bus.out_valid) begin
                pulses++;
                if (pulses == 1) first = c;
                else begin
                    second = c; got = bus.data_out; bus.in_valid = 1'b0;
                    break;
                end
            end
            @(negedge clk); c++;
        end
        bus.in_valid = 1'b0;
        m_hi = p[63:32]; m_lo = p[31:0];
        n_chk++;
        if (first != 33 || second != 34) begin
            n_fail++; $display("FAIL mflo_hold_timing: pulses at %0d,%0d, want 33,34", first, second);
        end
        n_chk++;
        if (got !== m_lo) begin
            n_fail++; $display("FAIL mflo_hold_data: got %h want %h", got, m_lo);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        drive(6'b111111, $urandom, $urandom, 5'd0);
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.data_out !== 32'h0 || bus.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal: vld=%b ill=%b dout=%h ovf=%b, want 1 1 0 0",
                     bus.out_valid, bus.illegal, bus.data_out, bus.ovf);
        end
`ifndef ALU_MDU_DIVU_EN
        drive(F_DIVU, 32'd100, 32'd7, 5'd0);
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL divu_disabled: vld=%b ill=%b rdy=%b, want 1 1 1", bus.out_valid, bus.illegal, bus.in_ready);
        end
`endif
        drive(F_MFHI, 32'h0, 32'h0, 5'd0);
        n_chk++;
        if (bus.data_out !== m_hi) begin
            n_fail++; $display("FAIL illegal_hi: got %h want %h", bus.data_out, m_hi);
        end
        drive(F_MFLO, 32'h0, 32'h0, 5'd0);
        n_chk++;
        if (bus.data_out !== m_lo) begin
            n_fail++; $display("FAIL illegal_lo: got %h want %h", bus.data_out, m_lo);
        end
    endtask

`ifdef ALU_MDU_DIVU_EN
    task automatic test_divu();
        logic [31:0] a, b, q, r; int lat;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 32'd7 : (i == 1) ? 32'd100 : $urandom;
            b = (i == 0) ? 32'd0 : (i == 1) ? 32'd7 : (i == 2) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            if (b == 0) begin q = 32'hFFFF_FFFF; r = a; end
            else begin q = a / b; r = a % b; end
            drive(F_DIVU, a, b, 5'd0);
            lat = 1;
            while (!bus.out_valid && lat < 100) begin @(negedge clk); lat++; end
            m_hi = r; m_lo = q;
            n_chk++;
            if (lat != 33 || bus.data_out !== q || bus.illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL divu_lo %h/%h: lat=%0d dout=%h ill=%b, want 33 %h 0", a, b, lat, bus.data_out, bus.illegal, q);
            end
            drive(F_MFHI, 32'h0, 32'h0, 5'd0);
            n_chk++;
            if (bus.data_out !== r) begin
                n_fail++; $display("FAIL divu_hi %h/%h: got %h want %h", a, b, bus.data_out, r);
            end
        end
    endtask
`endif

    task automatic test_reset_mid_mul();
        int pulses;
        drive(F_MULTU, 32'hFFFF_FFFF, 32'h1234_5678, 5'd0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        n_chk++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: rdy=%b vld=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        n_chk++;
        if (pulses != 0) begin
            n_fail++; $display("FAIL rst_no_pulse: saw %0d out_valid pulses, want 0", pulses);
        end
        drive(F_MFHI, 32'h0, 32'h0, 5'd0);
        n_chk++;
        if (bus.data_out !== 32'h0) begin
            n_fail++; $display("FAIL rst_hi: got %h want 00000000", bus.data_out);
        end
        drive(F_MFLO, 32'h0, 32'h0, 5'd0);
        n_chk++;
        if (bus.data_out !== 32'h0) begin
            n_fail++; $display("FAIL rst_lo: got %h want 00000000", bus.data_out);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.funct = '0; bus.data_a = '0; bus.data_b = '0; bus.shamt = '0;
        test_reset();
        test_back_to_back();
        test_slt_shift();
        test_random_single();
        test_multu();
        test_mflo_hold();
        test_illegal();
`ifdef ALU_MDU_DIVU_EN
        test_divu();
`endif
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
